// File: rtl/i2c_pkg.sv
// Shared I2C command definitions for the command queue and the AXIS-to-I2C transmitter.
// The packed word is LSB-first: address in the low bits, then R/W, then the data byte.
package i2c_pkg;

   localparam int I2C_ADDR_WIDTH  = 7;
   localparam int I2C_DATA_WIDTH  = 8;
   localparam int AXIS_DATA_WIDTH = I2C_DATA_WIDTH * 2;

   typedef struct packed {
      logic [I2C_DATA_WIDTH-1:0] data;
      logic                      rw;
      logic [I2C_ADDR_WIDTH-1:0] addr;
   } i2c_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_VALID,
      ST_GAP
   } q_state_t;

   function automatic i2c_cmd_t pack_cmd(input logic [I2C_ADDR_WIDTH-1:0] addr,
                                         input logic                      rw,
                                         input logic [I2C_DATA_WIDTH-1:0] data);
      i2c_cmd_t cmd;
      cmd.addr = addr;
      cmd.rw   = rw;
      cmd.data = data;
      return cmd;
   endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle (tdata/tvalid/tready) between the queue and the transmitter.
interface axis_if #(
   parameter int DATA_WIDTH = 16
) ();
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; read data is presented combinationally from the read pointer.
// Full and empty come from the occupancy count, pointers wrap modulo DEPTH.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage array; contents need no reset because count guards every read
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers and occupancy; a simultaneous write and read leaves the count unchanged
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axis_i2c_cmd_queue.sv
// Host-facing I2C command queue: buffers packed commands in a FIFO, presents them one at a
// time on an AXIS master, and holds the stream idle for GAP_CYCLES after every handshake.
module axis_i2c_cmd_queue #(
   parameter int I2C_ADDR_WIDTH  = 7,
   parameter int I2C_DATA_WIDTH  = 8,
   parameter int AXIS_DATA_WIDTH = I2C_DATA_WIDTH * 2,
   parameter int DEPTH           = 4,
   parameter int GAP_CYCLES      = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [I2C_ADDR_WIDTH-1:0] cmd_addr,
   input  logic                      cmd_rw,
   input  logic [I2C_DATA_WIDTH-1:0] cmd_data,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic                      busy,
   axis_if.master                    m_axis
);

   import i2c_pkg::q_state_t;
   import i2c_pkg::ST_IDLE;
   import i2c_pkg::ST_VALID;
   import i2c_pkg::ST_GAP;

   // The counter only ever holds GAP_CYCLES-1 down to 0
   localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

   q_state_t                   state;
   q_state_t                   state_next;
   logic [GW-1:0]              gap_cnt;
   logic [AXIS_DATA_WIDTH-1:0] packed_word;
   logic [AXIS_DATA_WIDTH-1:0] fifo_rd_data;
   logic [AXIS_DATA_WIDTH-1:0] out_word;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       push;
   logic                       pop;
   logic                       tvalid_int;
   logic                       handshake;

   assign packed_word = {cmd_data, cmd_rw, cmd_addr};
   assign cmd_ready   = !fifo_full && !rst;
   assign push        = cmd_valid && cmd_ready;
   assign handshake   = (state == ST_VALID) && m_axis.tready;

   assign m_axis.tvalid = tvalid_int;
   assign m_axis.tdata  = out_word;

   sync_fifo #(
      .WIDTH (AXIS_DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (packed_word),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: pop when idle, wait for the handshake, then sit out the bus-free gap
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_next = ST_VALID;
            end
         end
         ST_VALID: begin
            if (m_axis.tready) begin
               state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_cnt == '0) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Outputs decoded from state: the pop happens only in IDLE so tdata never moves under tvalid
   always_comb begin
      pop        = (state == ST_IDLE) && !fifo_empty;
      tvalid_int = (state == ST_VALID);
      busy       = (state != ST_IDLE) || (fifo_count != '0);
   end

   // Gap counter: loaded on the handshake, counted down while in GAP
   always_ff @(posedge clk) begin
      if (rst) begin
         gap_cnt <= '0;
      end else if (handshake && (GAP_CYCLES > 0)) begin
         gap_cnt <= GAP_LOAD;
      end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
         gap_cnt <= gap_cnt - 1'b1;
      end
   end

   // Output register: captures the FIFO head on each pop and holds it through the handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         out_word <= '0;
      end else if (pop) begin
         out_word <= fifo_rd_data;
      end
   end

endmodule

// File: tb/tb_axis_i2c_cmd_queue.sv
// Self-checking bench for axis_i2c_cmd_queue: table of commands with packed expectations,
// a scoreboard of words popped on each AXIS handshake, and short hand-timed sequences for
// latency, gap spacing, full stall, reset flush and simultaneous push/pop.
module tb_axis_i2c_cmd_queue;

   localparam int DEPTH = 4;
   localparam int GAP   = 4;

   typedef struct {
      logic [6:0]  addr;
      logic        rw;
      logic [7:0]  data;
      logic [15:0] exp_word;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_rw = 1'b0;
   logic [6:0]  cmd_addr = '0;
   logic [7:0]  cmd_data = '0;
   logic        cmd_ready;
   logic [2:0]  fifo_count;
   logic        busy;

   logic        h0_valid = 1'b0;
   logic        h0_rw = 1'b0;
   logic [6:0]  h0_addr = '0;
   logic [7:0]  h0_data = '0;
   logic        h0_ready;
   logic [2:0]  h0_count;
   logic        h0_busy;

   int          n_compared = 0;
   int          n_mismatched = 0;
   int          cycle = 0;
   int          ready_mode = 0;
   logic [15:0] sb[$];

   logic        prev_v = 1'b0;
   logic        prev_hs = 1'b0;
   logic        prev_rst = 1'b1;
   logic [15:0] prev_d = '0;
   int          last_hs_edge = 0;
   int          last_gap = 0;

   axis_if #(.DATA_WIDTH(16)) axis ();
   axis_if #(.DATA_WIDTH(16)) axis0 ();

   assign axis0.tready = 1'b1;

   axis_i2c_cmd_queue #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_rw     (cmd_rw),
      .cmd_data   (cmd_data),
      .fifo_count (fifo_count),
      .busy       (busy),
      .m_axis     (axis)
   );

   axis_i2c_cmd_queue #(.DEPTH(DEPTH), .GAP_CYCLES(0)) dut0 (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (h0_valid),
      .cmd_ready  (h0_ready),
      .cmd_addr   (h0_addr),
      .cmd_rw     (h0_rw),
      .cmd_data   (h0_data),
      .fifo_count (h0_count),
      .busy       (h0_busy),
      .m_axis     (axis0)
   );

   // Free-running clock and edge counter
   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   // Reference packing: address LSBs, then R/W, then data
   function automatic logic [15:0] make_word(input logic [6:0] a, input logic r, input logic [7:0] d);
      return {d, r, a};
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic report_timeout(input string name);
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s: bound expired, got no event, expected one (edge %0d)", name, cycle);
   endtask

   // Transmitter model: 0 = tready low, 1 = tready high, 2 = raise tready a cycle after tvalid
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       axis.tready = 1'b0;
         1:       axis.tready = 1'b1;
         default: axis.tready = prev_v && !prev_hs && axis.tvalid;
      endcase
   end

   // Monitor: hold checks while tvalid waits, scoreboard compare on each handshake
   always @(negedge clk) begin
      logic [15:0] exp_word;
      if (prev_v && !prev_hs && !prev_rst) begin
         check_output("tvalid_hold", axis.tvalid, 1);
         check_output("tdata_hold", axis.tdata, prev_d);
      end
      if (axis.tvalid && !prev_v) begin
         last_gap = cycle - last_hs_edge;
      end
      if (axis.tvalid && axis.tready) begin
         if (sb.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", axis.tdata);
         end else begin
            exp_word = sb.pop_front();
            check_output("tdata_order", axis.tdata, exp_word);
         end
         last_hs_edge = cycle + 1;
      end
      prev_v   = axis.tvalid;
      prev_hs  = axis.tvalid && axis.tready;
      prev_rst = rst;
      prev_d   = axis.tdata;
   end

   // Present one command, push its expected word, and wait (bounded) for acceptance
   task automatic apply_stimulus(input logic [6:0] a, input logic r, input logic [7:0] d,
                                 input logic [15:0] exp, input int limit, output int acc_edge);
      bit ok = 1'b0;
      cmd_addr  = a;
      cmd_rw    = r;
      cmd_data  = d;
      cmd_valid = 1'b1;
      sb.push_back(exp);
      acc_edge  = -1;
      for (int i = 0; i < limit && !ok; i++) begin
         @(negedge clk);
         ok = cmd_ready;
         @(posedge clk);
         #1;
      end
      if (ok) begin
         acc_edge = cycle;
      end else begin
         report_timeout("push_accept");
         void'(sb.pop_back());
      end
      cmd_valid = 1'b0;
   endtask

   // Wait until every expected word is delivered and busy has dropped
   task automatic wait_idle(input int limit, output int idle_edge);
      bit done = 1'b0;
      idle_edge = -1;
      for (int i = 0; i < limit && !done; i++) begin
         @(negedge clk);
         if (!busy && sb.size() == 0) begin
            done = 1'b1;
            idle_edge = cycle;
         end
         @(posedge clk);
         #1;
      end
      if (!done) report_timeout("drain_idle");
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs[6];
      int   k;
      int   idle_edge;

      vecs[0] = '{7'h50, 1'b0, 8'hA5, 16'hA550};
      vecs[1] = '{7'h3C, 1'b1, 8'h00, 16'h00BC};
      vecs[2] = '{7'h7F, 1'b1, 8'hFF, 16'hFFFF};
      vecs[3] = '{7'h00, 1'b0, 8'h00, 16'h0000};
      vecs[4] = '{7'h01, 1'b0, 8'h80, 16'h8001};
      vecs[5] = '{7'h2A, 1'b1, 8'h5A, 16'h5AAA};

      // Reset values
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("ready_in_reset", cmd_ready, 0);
      check_output("tvalid_in_reset", axis.tvalid, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_output("ready_after_reset", cmd_ready, 1);
      check_output("tvalid_after_reset", axis.tvalid, 0);
      check_output("tdata_after_reset", axis.tdata, 0);
      check_output("count_after_reset", fifo_count, 0);
      check_output("busy_after_reset", busy, 0);
      @(posedge clk);
      #1;

      // Single write: tvalid one edge after acceptance, busy drops GAP edges after handshake
      ready_mode = 2;
      apply_stimulus(7'h50, 1'b0, 8'hA5, 16'hA550, 4, k);
      @(negedge clk);
      check_output("single_count_1", fifo_count, 1);
      check_output("single_tvalid_early", axis.tvalid, 0);
      check_output("single_busy", busy, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_output("single_tvalid", axis.tvalid, 1);
      check_output("single_tdata", axis.tdata, 16'hA550);
      check_output("single_count_0", fifo_count, 0);
      @(posedge clk);
      #1;
      wait_idle(40, idle_edge);
      check_output("busy_fall_gap", idle_edge - last_hs_edge, GAP);

      // Table of commands through the scoreboard
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(vecs[i].addr, vecs[i].rw, vecs[i].data, vecs[i].exp_word, 20, k);
      end
      wait_idle(200, idle_edge);

      // Burst of 6 with tready low: output register plus a full FIFO, the 6th stalls
      ready_mode = 0;
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(7'(16 + i), i[0], 8'(192 + i),
                        make_word(7'(16 + i), i[0], 8'(192 + i)), 4, k);
      end
      @(negedge clk);
      check_output("burst_count_full", fifo_count, 4);
      check_output("burst_ready_full", cmd_ready, 0);
      check_output("burst_head_tdata", axis.tdata, 16'hC010);
      @(posedge clk);
      #1;
      fork
         apply_stimulus(7'h15, 1'b1, 8'hC5, make_word(7'h15, 1'b1, 8'hC5), 60, k);
         begin
            repeat (3) begin
               @(negedge clk);
               check_output("burst_stall_ready", cmd_ready, 0);
            end
            @(posedge clk);
            #1;
            ready_mode = 2;
         end
      join
      wait_idle(300, idle_edge);

      // Gap spacing with tready always high: next tvalid GAP+1 edges after the handshake
      ready_mode = 1;
      apply_stimulus(7'h21, 1'b0, 8'h11, 16'h1121, 4, k);
      apply_stimulus(7'h22, 1'b1, 8'h12, 16'h12A2, 4, k);
      wait_idle(60, idle_edge);
      check_output("gap4_spacing", last_gap, GAP + 1);

      // Zero-gap instance: next word the edge after the handshake, push/pop keeps count
      h0_addr  = 7'h11;
      h0_rw    = 1'b0;
      h0_data  = 8'h22;
      h0_valid = 1'b1;
      @(posedge clk);
      #1;
      h0_addr = 7'h33;
      h0_rw   = 1'b1;
      h0_data = 8'h44;
      @(posedge clk);
      #1;
      h0_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check_output("gap0_tvalid", axis0.tvalid, (j % 2 == 0) ? 1 : 0);
         if (j == 0) begin
            check_output("gap0_tdata_a", axis0.tdata, 16'h2211);
            check_output("gap0_count_pushpop", h0_count, 1);
         end
         if (j == 2) begin
            check_output("gap0_tdata_b", axis0.tdata, 16'h44B3);
            check_output("gap0_count_empty", h0_count, 0);
         end
         @(posedge clk);
         #1;
      end

      // Reset while VALID with 2 words queued: everything flushed, nothing stale afterwards
      ready_mode = 0;
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(7'(48 + i), 1'b0, 8'(i), make_word(7'(48 + i), 1'b0, 8'(i)), 4, k);
      end
      @(negedge clk);
      check_output("pre_reset_tvalid", axis.tvalid, 1);
      check_output("pre_reset_count", fifo_count, 2);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check_output("mid_reset_ready", cmd_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      check_output("flush_tvalid", axis.tvalid, 0);
      check_output("flush_count", fifo_count, 0);
      check_output("flush_busy", busy, 0);
      ready_mode = 2;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_output("no_stale_word", axis.tvalid, 0);
      end
      @(posedge clk);
      #1;

      // Push and pop on the same edge with 2 queued, then keep going past pointer wrap
      ready_mode = 0;
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(7'(64 + i), i[1], 8'h5A ^ 8'(i * 17),
                        make_word(7'(64 + i), i[1], 8'h5A ^ 8'(i * 17)), 4, k);
      end
      @(negedge clk);
      check_output("pp_count_before", fifo_count, 2);
      @(posedge clk);
      #1;
      ready_mode = 1;
      repeat (5) @(posedge clk);
      #1;
      cmd_addr  = 7'h43;
      cmd_rw    = 1'b0;
      cmd_data  = 8'h5A ^ 8'(3 * 17);
      cmd_valid = 1'b1;
      sb.push_back(make_word(7'h43, 1'b0, 8'h5A ^ 8'(3 * 17)));
      @(negedge clk);
      check_output("pp_idle_tvalid", axis.tvalid, 0);
      check_output("pp_ready", cmd_ready, 1);
      check_output("pp_count_pre", fifo_count, 2);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check_output("pp_count_after", fifo_count, 2);
      check_output("pp_popped_tvalid", axis.tvalid, 1);
      check_output("pp_popped_tdata", axis.tdata, make_word(7'h41, 1'b0, 8'h5A ^ 8'(17)));
      @(posedge clk);
      #1;
      ready_mode = 2;
      for (int i = 4; i < 12; i++) begin
         apply_stimulus(7'(64 + i), i[1], 8'h5A ^ 8'(i * 17),
                        make_word(7'(64 + i), i[1], 8'h5A ^ 8'(i * 17)), 30, k);
      end
      wait_idle(400, idle_edge);
      check_output("final_count", fifo_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
